// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV bit positions and FlagW field meanings.
package cpu_pkg;

  localparam int ALU_FLAGS_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  typedef logic [ALU_FLAGS_W-1:0] flags_t;

  typedef enum logic [3:0] {
    EQ  = 4'b0000,
    NE  = 4'b0001,
    CS  = 4'b0010,
    CC  = 4'b0011,
    MI  = 4'b0100,
    PL  = 4'b0101,
    VS  = 4'b0110,
    VC  = 4'b0111,
    HI  = 4'b1000,
    LS  = 4'b1001,
    GE  = 4'b1010,
    LT  = 4'b1011,
    GT  = 4'b1100,
    LE  = 4'b1101,
    AL  = 4'b1110,
    UNC = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU to conditional-execution stage signal bundle.
interface cond_unit_if;
  logic                              en;
  logic [3:0]                        Cond;
  logic [cpu_pkg::ALU_FLAGS_W-1:0]   ALUFlags;
  logic [1:0]                        FlagW;
  logic                              PCS;
  logic                              RegW;
  logic                              MemW;
  logic                              PCSrc;
  logic                              RegWrite;
  logic                              MemWrite;
  logic                              CondEx;
  logic [cpu_pkg::ALU_FLAGS_W-1:0]   Flags;

  modport master (
    output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  modport slave (
    input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );
endinterface

// File: rtl/cond_unit_check.sv
// Purely combinational evaluation of a 4-bit condition field against stored NZCV.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] Cond,
  input  flags_t     Flags,
  output logic       CondEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = Flags[FLAG_N];
  assign w_z = Flags[FLAG_Z];
  assign w_c = Flags[FLAG_C];
  assign w_v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b1;
    case (cond_e'(Cond))
      EQ:      CondEx = w_z;
      NE:      CondEx = ~w_z;
      CS:      CondEx = w_c;
      CC:      CondEx = ~w_c;
      MI:      CondEx = w_n;
      PL:      CondEx = ~w_n;
      VS:      CondEx = w_v;
      VC:      CondEx = ~w_v;
      HI:      CondEx = w_c & ~w_z;
      LS:      CondEx = ~w_c | w_z;
      GE:      CondEx = ~(w_n ^ w_v);
      LT:      CondEx = w_n ^ w_v;
      GT:      CondEx = ~w_z & ~(w_n ^ w_v);
      LE:      CondEx = w_z | (w_n ^ w_v);
      AL, UNC: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Architectural NZCV register plus condition-gated commit enables for PC, register file and memory.
module cond_unit
  import cpu_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  cond_unit_if.slave  bus
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       w_cond_ex;
  logic       w_commit;

  cond_check u_cond_check (
    .Cond   (bus.Cond),
    .Flags  ({r_nz, r_cv}),
    .CondEx (w_cond_ex)
  );

  // Reset also suppresses commits combinationally, not only the flag register.
  assign w_commit = bus.en & w_cond_ex & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nz <= RESET_FLAGS[3:2];
      r_cv <= RESET_FLAGS[1:0];
    end else begin
      if (w_commit && bus.FlagW[FLAGW_NZ]) begin
        r_nz <= bus.ALUFlags[FLAG_N:FLAG_Z];
      end
      if (w_commit && bus.FlagW[FLAGW_CV]) begin
        r_cv <= bus.ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

  assign bus.CondEx   = w_cond_ex;
  assign bus.Flags    = {r_nz, r_cv};
  assign bus.PCSrc    = bus.PCS  & w_commit;
  assign bus.RegWrite = bus.RegW & w_commit;
  assign bus.MemWrite = bus.MemW & w_commit;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: expectations queued at drive time, popped when outputs are sampled.
module tb_cond_unit;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cond_unit_if bus ();

  cond_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    string      tag;
    logic       rst;
    logic       en;
    logic [3:0] cond;
    logic [3:0] aluf;
    logic [1:0] fw;
    logic       pcs, regw, memw;
    logic [3:0] x_flags;
    logic       x_cex, x_pc, x_rw, x_mw;
  } step_t;

  step_t sb[$];

  function automatic step_t mk(string tag, logic rst, logic en, logic [3:0] cond,
                               logic [3:0] aluf, logic [1:0] fw, logic pcs, logic regw,
                               logic memw, logic [3:0] xf, logic xc, logic xp,
                               logic xr, logic xm);
    step_t s;
    s.tag = tag; s.rst = rst; s.en = en; s.cond = cond; s.aluf = aluf; s.fw = fw;
    s.pcs = pcs; s.regw = regw; s.memw = memw;
    s.x_flags = xf; s.x_cex = xc; s.x_pc = xp; s.x_rw = xr; s.x_mw = xm;
    return s;
  endfunction

  function automatic logic [7:0] obs();
    return {bus.Flags, bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite};
  endfunction

  function automatic logic [7:0] exp_vec(step_t s);
    return {s.x_flags, s.x_cex, s.x_pc, s.x_rw, s.x_mw};
  endfunction

  function automatic string fmt(logic [7:0] v);
    return $sformatf("flags=%b cex=%b pc=%b rw=%b mw=%b", v[7:4], v[3], v[2], v[1], v[0]);
  endfunction

  function automatic logic cond_ref(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic apply(step_t s);
    reset        = s.rst;
    bus.en       = s.en;
    bus.Cond     = s.cond;
    bus.ALUFlags = s.aluf;
    bus.FlagW    = s.fw;
    bus.PCS      = s.pcs;
    bus.RegW     = s.regw;
    bus.MemW     = s.memw;
  endtask

  task automatic test_reset();
    step_t st[$];
    step_t e;
    st.push_back(mk("rst_ne_gated", 1, 1, 4'b0001, 4'b1111, 2'b11, 1, 1, 1, 4'b0000, 1, 0, 0, 0));
    st.push_back(mk("rst_eq",       1, 1, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 4'b0000, 0, 0, 0, 0));
    st.push_back(mk("reset_eq",     0, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    st.push_back(mk("reset_ne",     0, 1, 4'b0001, 4'b0000, 2'b00, 0, 1, 0, 4'b0000, 1, 0, 1, 0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(st[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
    end
  endtask

  task automatic test_flag_set();
    step_t st[$];
    step_t e;
    st.push_back(mk("set_all_al", 0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 4'b0000, 1, 0, 0, 0));
    st.push_back(mk("set_all_eq", 0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 4'b0100, 1, 1, 0, 0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(st[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
    end
  endtask

  task automatic test_partial_write();
    step_t st[$];
    step_t e;
    st.push_back(mk("cv_only",   0, 1, 4'b1110, 4'b1011, 2'b01, 0, 1, 0, 4'b0100, 1, 0, 1, 0));
    st.push_back(mk("hi_fail",   0, 1, 4'b1000, 4'b0000, 2'b00, 0, 1, 0, 4'b0111, 0, 0, 0, 0));
    st.push_back(mk("nz_only",   0, 1, 4'b1110, 4'b1000, 2'b10, 0, 0, 0, 4'b0111, 1, 0, 0, 0));
    st.push_back(mk("cv_clear",  0, 1, 4'b1110, 4'b1000, 2'b01, 0, 0, 0, 4'b1011, 1, 0, 0, 0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(st[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
    end
  endtask

  task automatic test_signed();
    step_t st[$];
    step_t e;
    st.push_back(mk("lt_pass", 0, 1, 4'b1011, 4'b0000, 2'b11, 0, 1, 0, 4'b1000, 1, 0, 1, 0));
    st.push_back(mk("lt_fail", 0, 1, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    st.push_back(mk("gt_pass", 0, 1, 4'b1100, 4'b0000, 2'b00, 0, 1, 0, 4'b0000, 1, 0, 1, 0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(st[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
    end
  endtask

  task automatic test_cond_fail();
    step_t st[$];
    step_t e;
    st.push_back(mk("fail_no_write", 0, 1, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 4'b0000, 0, 0, 0, 0));
    st.push_back(mk("fail_held",     0, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 4'b0000, 1, 0, 0, 1));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(st[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    step_t e;
    st.push_back(mk("b2b_first",  0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 4'b0000, 1, 0, 0, 0));
    st.push_back(mk("b2b_second", 0, 1, 4'b0000, 4'b0001, 2'b11, 0, 1, 0, 4'b0100, 1, 0, 1, 0));
    st.push_back(mk("b2b_eq",     0, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 4'b0001, 0, 0, 0, 0));
    st.push_back(mk("b2b_vs",     0, 1, 4'b0110, 4'b0000, 2'b00, 0, 1, 0, 4'b0001, 1, 0, 1, 0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(st[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
    end
  endtask

  task automatic test_stall_reset();
    step_t st[$];
    step_t e;
    st.push_back(mk("pre_set",     0, 1, 4'b1110, 4'b0101, 2'b11, 0, 0, 0, 4'b0001, 1, 0, 0, 0));
    st.push_back(mk("stall",       0, 0, 4'b1110, 4'b1010, 2'b11, 0, 1, 0, 4'b0101, 1, 0, 0, 0));
    st.push_back(mk("stall_hold",  0, 0, 4'b1110, 4'b1010, 2'b11, 0, 1, 0, 4'b0101, 1, 0, 0, 0));
    st.push_back(mk("async_rst",   1, 0, 4'b1110, 4'b1010, 2'b11, 0, 1, 0, 4'b0000, 1, 0, 0, 0));
    st.push_back(mk("rst_release", 0, 1, 4'b1110, 4'b1010, 2'b11, 0, 1, 0, 4'b0000, 1, 0, 1, 0));
    st.push_back(mk("post_update", 0, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 4'b1010, 1, 0, 0, 0));
    st.push_back(mk("rst_vs_upd",  1, 1, 4'b1110, 4'b0101, 2'b11, 1, 1, 1, 4'b0000, 1, 0, 0, 0));
    st.push_back(mk("rst_won",     0, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 4'b0000, 1, 0, 0, 0));
    foreach (st[i]) begin
      @(negedge clk);
      apply(st[i]);
      sb.push_back(st[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] m_flags;
    step_t      s;
    step_t      e;
    logic       cx;
    logic       commit;
    m_flags = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      s.tag  = $sformatf("rand_%0d", i);
      s.rst  = 1'b0;
      s.en   = ($urandom_range(0, 4) != 0);
      s.cond = 4'($urandom_range(0, 15));
      s.aluf = 4'($urandom_range(0, 15));
      s.fw   = 2'($urandom_range(0, 3));
      s.pcs  = 1'($urandom_range(0, 1));
      s.regw = 1'($urandom_range(0, 1));
      s.memw = 1'($urandom_range(0, 1));
      cx     = cond_ref(s.cond, m_flags);
      commit = cx && s.en;
      s.x_flags = m_flags;
      s.x_cex   = cx;
      s.x_pc    = s.pcs && commit;
      s.x_rw    = s.regw && commit;
      s.x_mw    = s.memw && commit;
      @(negedge clk);
      apply(s);
      sb.push_back(s);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs() !== exp_vec(e)) begin
        errors++;
        $display("FAIL %s: got %s, expected %s", e.tag, fmt(obs()), fmt(exp_vec(e)));
      end
      if (commit && s.fw[1]) m_flags[3:2] = s.aluf[3:2];
      if (commit && s.fw[0]) m_flags[1:0] = s.aluf[1:0];
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.Cond     = 4'b0000;
    bus.ALUFlags = 4'b0000;
    bus.FlagW    = 2'b00;
    bus.PCS      = 1'b0;
    bus.RegW     = 1'b0;
    bus.MemW     = 1'b0;
    test_reset();
    test_flag_set();
    test_partial_write();
    test_signed();
    test_cond_fail();
    test_back_to_back();
    test_stall_reset();
    test_random();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution and flags stage, directly downstream of the ALU; consumes the ALU's 4-bit NZCV flags.
- Holds the architectural NZCV flags register.
- Evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the decoder's write/branch enables so only instructions whose condition passes can commit state.

Parameters:
RESET_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  stage enable; 0 = stall (no commit, flags hold)
Cond  in  4  instruction condition field
ALUFlags  in  4  ALU result flags {N,Z,C,V}, bit3=N … bit0=V
FlagW  in  2  flag write request; bit1 = update N,Z; bit0 = update C,V
PCS  in  1  decoder: instruction writes PC
RegW  in  1  decoder: instruction writes register file
MemW  in  1  decoder: instruction writes memory
PCSrc  out  1  gated PC write
RegWrite  out  1  gated register write
MemWrite  out  1  gated memory write
CondEx  out  1  condition passed (from stored flags)
Flags  out  4  current stored {N,Z,C,V}

Behaviour:
- Flags register: two independent 2-bit fields, NZ = Flags[3:2] and CV = Flags[1:0].
- Reset: asserting reset clears both fields to RESET_FLAGS immediately, independent of clk. While reset is high:
  - Flags = RESET_FLAGS.
  - CondEx is evaluated on RESET_FLAGS.
  - PCSrc, RegWrite, MemWrite are 0.
- CondEx is combinational from Cond and stored Flags only; it never depends on the current ALUFlags. Condition table:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 1 (unconditional)
- Gated outputs, all combinational, zero latency:
  - PCSrc = PCS & CondEx & en
  - RegWrite = RegW & CondEx & en
  - MemWrite = MemW & CondEx & en
- Flag update on rising clk, when en & CondEx & !reset:
  - FlagW[1] = 1: NZ <= ALUFlags[3:2].
  - FlagW[0] = 1: CV <= ALUFlags[1:0].
  - Each field is written independently; an unselected field holds.
- Condition failed (CondEx = 0): no flag update even if FlagW ≠ 0; all gated outputs 0.
- en = 0: flags hold, all gated outputs 0, CondEx still reported.
- Back-to-back flag-setting instructions: the second instruction's CondEx uses flags written at the end of the first instruction's cycle (one-cycle visibility). There is no combinational bypass of ALUFlags into CondEx.
- Reset mid-stall or mid-update: reset wins; flags are RESET_FLAGS at the next edge regardless of en/FlagW.
- No X propagation: every Cond code is defined, so there is no default-to-X case.

Decomposition:
- Shared package cpu_pkg:
  - cond_e enum: EQ…AL, UNC for 1111.
  - Flag bit index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit meanings: FLAGW_NZ=1, FLAGW_CV=0.
  - ALU flag width constant (4).
- One natural sub-module: cond_check.
  - Purely combinational.
  - Inputs: Cond, Flags. Output: CondEx.
  - Implements the table above.
- cond_unit holds the registers and the gating.

Test Plan:
1. Reset then Cond=0000 (EQ), RegW=1, en=1:
   - Flags=0000, CondEx=0, RegWrite=0.
   - Same with Cond=0001 (NE): CondEx=1, RegWrite=1.
2. FlagW=11, Cond=1110, ALUFlags=0100, en=1, one clk:
   - Flags=0100.
   - Next cycle Cond=0000: CondEx=1, and PCS=1 gives PCSrc=1.
3. Flags=0100; FlagW=01, ALUFlags=1011, Cond=1110:
   - After clk Flags=0111 (NZ held, CV written).
   - Then Cond=1000 (HI): CondEx=0, since C=1 but Z=1.
4. Flags=1000 (N=1, V=0); Cond=1011 (LT), FlagW=11, ALUFlags=0000:
   - CondEx=1 and flags update to 0000.
   - Next cycle Cond=1011: CondEx=0 (LT now fails).
   - Cond=1100 (GT): CondEx=1.
5. Flags=0000, Cond=0000 (fails), FlagW=11, ALUFlags=1111, MemW=1:
   - MemWrite=0.
   - After clk Flags still 0000.
6. Cond=1110, FlagW=11, ALUFlags=1010, en=0: Flags unchanged and RegWrite=0. Then:
   - Assert reset asynchronously between edges: Flags becomes 0000 before the next clk edge.
   - Release reset with en=1: the next edge updates Flags to 1010.
